// File: rtl/combat_round_controller.sv
`timescale 1ns/1ps
// combat_round_controller
//   Sequences one fight round between player 1 (left) and player 2 (right).
//   Each player has an attack FSM (READY -> WINDUP -> ACTIVE -> COOLDOWN).
//   Hits landed in ACTIVE are arbitrated, including same-tick trades. Damage
//   is applied to both health registers, and a KO ends the round.
//   All state moves on the 20 Hz game tick. The only exception is the attack
//   request latch, which runs on every clk.
//
// Ports
//   clk                  100 MHz system clock
//   reset                synchronous, active-high, dominant
//   tick                 one-clk game tick enable
//   start                level; starts a round from IDLE
//   p1_attack/p2_attack  attack buttons (level, synchronised)
//   p1_block/p2_block    block buttons (level)
//   in_range             players overlap or are adjacent
//   health_l/health_r    player 1 / player 2 health (5 bit)
//   p1_state/p2_state    0 READY, 1 WINDUP, 2 ACTIVE, 3 COOLDOWN
//   round_state          0 IDLE, 1 FIGHT, 2 KO
//   winner               0 none, 1 player 1, 2 player 2, 3 draw
module combat_round_controller #(
  parameter int MAX_HEALTH     = 31,
  parameter int HIT_DAMAGE     = 3,
  parameter int BLOCK_DAMAGE   = 1,
  parameter int WINDUP_TICKS   = 2,
  parameter int ACTIVE_TICKS   = 2,
  parameter int COOLDOWN_TICKS = 6,
  parameter int KO_TICKS       = 40
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       start,
  input  logic       p1_attack,
  input  logic       p2_attack,
  input  logic       p1_block,
  input  logic       p2_block,
  input  logic       in_range,
  output logic [4:0] health_l,
  output logic [4:0] health_r,
  output logic [1:0] p1_state,
  output logic [1:0] p2_state,
  output logic [1:0] round_state,
  output logic [1:0] winner
);

  localparam int ATK_MAX0 = (WINDUP_TICKS > ACTIVE_TICKS) ? WINDUP_TICKS : ACTIVE_TICKS;
  localparam int ATK_MAX  = (ATK_MAX0 > COOLDOWN_TICKS) ? ATK_MAX0 : COOLDOWN_TICKS;
  localparam int ATK_W    = $clog2(ATK_MAX + 1);
  localparam int KO_W     = $clog2(KO_TICKS + 1);

  localparam logic [4:0]       MAX_H   = 5'(MAX_HEALTH);
  localparam logic [4:0]       HIT_D   = 5'(HIT_DAMAGE);
  localparam logic [4:0]       BLK_D   = 5'(BLOCK_DAMAGE);
  localparam logic [ATK_W-1:0] WIND_LD = ATK_W'(WINDUP_TICKS - 1);
  localparam logic [ATK_W-1:0] ACT_LD  = ATK_W'(ACTIVE_TICKS - 1);
  localparam logic [ATK_W-1:0] COOL_LD = ATK_W'(COOLDOWN_TICKS - 1);
  localparam logic [KO_W-1:0]  KO_LD   = KO_W'(KO_TICKS - 1);

  typedef enum logic [1:0] {
    ATK_READY    = 2'd0,
    ATK_WINDUP   = 2'd1,
    ATK_ACTIVE   = 2'd2,
    ATK_COOLDOWN = 2'd3
  } atk_t;

  typedef enum logic [1:0] {
    RND_IDLE  = 2'd0,
    RND_FIGHT = 2'd1,
    RND_KO    = 2'd2
  } rnd_t;

  typedef struct packed {
    atk_t             st;
    logic [ATK_W-1:0] cnt;
  } atk_nxt_t;

  // Health minus damage, clamped at zero. The 6-bit signed difference
  // cannot wrap for any 5-bit operands.
  function automatic logic [4:0] sat_sub(input logic [4:0] h, input logic [4:0] d);
    logic signed [5:0] diff;
    diff = $signed({1'b0, h}) - $signed({1'b0, d});
    return (diff < 0) ? 5'd0 : diff[4:0];
  endfunction

  // One tick of an attack FSM. A pending request is consumed only from READY.
  function automatic atk_nxt_t atk_step(input atk_t st, input logic [ATK_W-1:0] cnt,
                                        input logic pend);
    atk_nxt_t n;
    n.st  = st;
    n.cnt = cnt;
    case (st)
      ATK_READY: begin
        if (pend) begin
          n.st  = ATK_WINDUP;
          n.cnt = WIND_LD;
        end
      end
      ATK_WINDUP: begin
        if (cnt == '0) begin
          n.st  = ATK_ACTIVE;
          n.cnt = ACT_LD;
        end else begin
          n.cnt = cnt - ATK_W'(1);
        end
      end
      ATK_ACTIVE: begin
        if (cnt == '0) begin
          n.st  = ATK_COOLDOWN;
          n.cnt = COOL_LD;
        end else begin
          n.cnt = cnt - ATK_W'(1);
        end
      end
      ATK_COOLDOWN: begin
        if (cnt == '0) begin
          n.st  = ATK_READY;
          n.cnt = '0;
        end else begin
          n.cnt = cnt - ATK_W'(1);
        end
      end
      default: begin
        n.st  = ATK_READY;
        n.cnt = '0;
      end
    endcase
    return n;
  endfunction

  rnd_t             rnd_q, rnd_d;
  atk_t             p1_q, p1_d, p2_q, p2_d;
  logic [ATK_W-1:0] p1_cnt_q, p1_cnt_d, p2_cnt_q, p2_cnt_d;
  logic [KO_W-1:0]  ko_cnt_q, ko_cnt_d;
  logic [4:0]       hl_q, hl_d, hr_q, hr_d;
  logic [1:0]       win_q, win_d;
  logic             p1_pend_q, p1_pend_d, p2_pend_q, p2_pend_d;
  logic             p1_hd_q, p1_hd_d, p2_hd_q, p2_hd_d;
  logic             p1_atk_q, p2_atk_q;

  logic       p1_edge, p2_edge;
  logic       p1_hit, p2_hit;
  logic [4:0] dmg_l, dmg_r, hl_new, hr_new;
  atk_nxt_t   p1_n, p2_n;

  assign p1_edge = p1_attack & ~p1_atk_q;
  assign p2_edge = p2_attack & ~p2_atk_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rnd_q     <= RND_IDLE;
      p1_q      <= ATK_READY;
      p2_q      <= ATK_READY;
      p1_cnt_q  <= '0;
      p2_cnt_q  <= '0;
      ko_cnt_q  <= '0;
      hl_q      <= MAX_H;
      hr_q      <= MAX_H;
      win_q     <= 2'd0;
      p1_pend_q <= 1'b0;
      p2_pend_q <= 1'b0;
      p1_hd_q   <= 1'b0;
      p2_hd_q   <= 1'b0;
      p1_atk_q  <= 1'b0;
      p2_atk_q  <= 1'b0;
    end else begin
      rnd_q     <= rnd_d;
      p1_q      <= p1_d;
      p2_q      <= p2_d;
      p1_cnt_q  <= p1_cnt_d;
      p2_cnt_q  <= p2_cnt_d;
      ko_cnt_q  <= ko_cnt_d;
      hl_q      <= hl_d;
      hr_q      <= hr_d;
      win_q     <= win_d;
      p1_pend_q <= p1_pend_d;
      p2_pend_q <= p2_pend_d;
      p1_hd_q   <= p1_hd_d;
      p2_hd_q   <= p2_hd_d;
      p1_atk_q  <= p1_attack;
      p2_atk_q  <= p2_attack;
    end
  end

  always_comb begin
    rnd_d     = rnd_q;
    p1_d      = p1_q;
    p2_d      = p2_q;
    p1_cnt_d  = p1_cnt_q;
    p2_cnt_d  = p2_cnt_q;
    ko_cnt_d  = ko_cnt_q;
    hl_d      = hl_q;
    hr_d      = hr_q;
    win_d     = win_q;
    p1_pend_d = p1_pend_q;
    p2_pend_d = p2_pend_q;
    p1_hd_d   = p1_hd_q;
    p2_hd_d   = p2_hd_q;

    // A block only helps a defender that is not itself mid-attack.
    p1_hit = (p1_q == ATK_ACTIVE) && in_range && !p1_hd_q;
    p2_hit = (p2_q == ATK_ACTIVE) && in_range && !p2_hd_q;
    dmg_r  = (p2_block && (p2_q == ATK_READY)) ? BLK_D : HIT_D;
    dmg_l  = (p1_block && (p1_q == ATK_READY)) ? BLK_D : HIT_D;
    hr_new = p1_hit ? sat_sub(hr_q, dmg_r) : hr_q;
    hl_new = p2_hit ? sat_sub(hl_q, dmg_l) : hl_q;
    p1_n   = atk_step(p1_q, p1_cnt_q, p1_pend_q);
    p2_n   = atk_step(p2_q, p2_cnt_q, p2_pend_q);

    // Request latch runs every clk. Presses outside FIGHT+READY are dropped.
    if (rnd_q != RND_FIGHT) begin
      p1_pend_d = 1'b0;
      p2_pend_d = 1'b0;
    end else begin
      if (p1_edge && (p1_q == ATK_READY)) p1_pend_d = 1'b1;
      if (p2_edge && (p2_q == ATK_READY)) p2_pend_d = 1'b1;
    end

    if (tick) begin
      case (rnd_q)
        RND_IDLE: begin
          hl_d = MAX_H;
          hr_d = MAX_H;
          p1_d = ATK_READY;
          p2_d = ATK_READY;
          if (start) begin
            rnd_d = RND_FIGHT;
            win_d = 2'd0;
          end
        end
        RND_FIGHT: begin
          p1_d     = p1_n.st;
          p1_cnt_d = p1_n.cnt;
          p2_d     = p2_n.st;
          p2_cnt_d = p2_n.cnt;
          if ((p1_q == ATK_READY) && p1_pend_q) begin
            p1_pend_d = 1'b0;
            p1_hd_d   = 1'b0;
          end
          if ((p2_q == ATK_READY) && p2_pend_q) begin
            p2_pend_d = 1'b0;
            p2_hd_d   = 1'b0;
          end
          if (p1_hit) p1_hd_d = 1'b1;
          if (p2_hit) p2_hd_d = 1'b1;
          hl_d = hl_new;
          hr_d = hr_new;
          // KO is judged on post-damage health so trades resolve as a draw.
          if ((hl_new == 5'd0) || (hr_new == 5'd0)) begin
            rnd_d    = RND_KO;
            ko_cnt_d = KO_LD;
            p1_d     = ATK_READY;
            p2_d     = ATK_READY;
            if ((hl_new == 5'd0) && (hr_new == 5'd0)) win_d = 2'd3;
            else if (hr_new == 5'd0)                  win_d = 2'd1;
            else                                      win_d = 2'd2;
          end
        end
        RND_KO: begin
          p1_d = ATK_READY;
          p2_d = ATK_READY;
          if (ko_cnt_q == '0) begin
            rnd_d = RND_IDLE;
            hl_d  = MAX_H;
            hr_d  = MAX_H;
          end else begin
            ko_cnt_d = ko_cnt_q - KO_W'(1);
          end
        end
        default: rnd_d = RND_IDLE;
      endcase
    end
  end

  assign health_l    = hl_q;
  assign health_r    = hr_q;
  assign p1_state    = p1_q;
  assign p2_state    = p2_q;
  assign round_state = rnd_q;
  assign winner      = win_q;

endmodule

// File: tb/tb_combat_round_controller.sv
`timescale 1ns/1ps
// Testbench for combat_round_controller. Expected values are pushed to a
// scoreboard queue as stimulus is applied. They are popped and compared
// once the DUT has produced the corresponding output.
module tb_combat_round_controller;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       start = 1'b0;
  logic       p1_attack = 1'b0;
  logic       p2_attack = 1'b0;
  logic       p1_block = 1'b0;
  logic       p2_block = 1'b0;
  logic       in_range = 1'b0;
  logic [4:0] health_l, health_r;
  logic [1:0] p1_state, p2_state, round_state, winner;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  string      name_q[$];

  always #5 clk = ~clk;

  combat_round_controller dut (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick),
    .start       (start),
    .p1_attack   (p1_attack),
    .p2_attack   (p2_attack),
    .p1_block    (p1_block),
    .p2_block    (p2_block),
    .in_range    (in_range),
    .health_l    (health_l),
    .health_r    (health_r),
    .p1_state    (p1_state),
    .p2_state    (p2_state),
    .round_state (round_state),
    .winner      (winner)
  );

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  // Game tick: 3 idle clks, then one tick clk. Returns on the negedge just
  // after the ticking posedge, so registered results are visible.
  task automatic do_tick();
    repeat (3) @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic press(input logic a1, input logic a2);
    p1_attack = a1;
    p2_attack = a2;
    @(negedge clk);
    p1_attack = 1'b0;
    p2_attack = 1'b0;
    @(negedge clk);
  endtask

  // A whole attack cycle: press, then 11 ticks (1 to leave READY + 2 + 2 + 6).
  task automatic play(input logic a1, input logic a2);
    press(a1, a2);
    repeat (11) do_tick();
  endtask

  task automatic expect_val(input string n, input logic [7:0] v);
    name_q.push_back(n);
    exp_q.push_back(v);
  endtask

  task automatic test_reset();
    logic [7:0] obs[6];
    logic [7:0] e;
    string n;
    p1_attack = 1'b1; p2_attack = 1'b1; p1_block = 1'b1; p2_block = 1'b1;
    in_range = 1'b1; start = 1'b1; tick = 1'b1;
    reset = 1'b1;
    expect_val("reset_health_l", 8'd31);
    expect_val("reset_health_r", 8'd31);
    expect_val("reset_round", 8'd0);
    expect_val("reset_p1_state", 8'd0);
    expect_val("reset_p2_state", 8'd0);
    expect_val("reset_winner", 8'd0);
    repeat (3) @(negedge clk);
    obs[0] = {3'b0, health_l};
    obs[1] = {3'b0, health_r};
    obs[2] = {6'b0, round_state};
    obs[3] = {6'b0, p1_state};
    obs[4] = {6'b0, p2_state};
    obs[5] = {6'b0, winner};
    for (int i = 0; i < 6; i++) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      checks++;
      if (obs[i] !== e) begin
        errors++;
        $display("FAIL %s: got %0d, expected %0d", n, obs[i], e);
      end
    end
    reset = 1'b0; tick = 1'b0; start = 1'b0;
    p1_attack = 1'b0; p2_attack = 1'b0; p1_block = 1'b0; p2_block = 1'b0;
    in_range = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_unblocked_hit();
    logic [7:0] e;
    string n;
    int st_seq[11] = '{1, 1, 2, 2, 3, 3, 3, 3, 3, 3, 0};
    int hr_seq[11] = '{31, 31, 31, 28, 28, 28, 28, 28, 28, 28, 28};
    start = 1'b1;
    expect_val("start_round", 8'd1);
    do_tick();
    e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
    if ({6'b0, round_state} !== e) begin
      errors++; $display("FAIL %s: got %0d, expected %0d", n, round_state, e);
    end
    // start held in FIGHT must not disturb the round
    expect_val("start_ignored_in_fight", 8'd1);
    do_tick();
    start = 1'b0;
    e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
    if ({6'b0, round_state} !== e) begin
      errors++; $display("FAIL %s: got %0d, expected %0d", n, round_state, e);
    end
    in_range = 1'b1;
    press(1'b1, 1'b0);
    for (int i = 0; i < 11; i++) begin
      expect_val($sformatf("hit_p1_state_t%0d", i + 1), 8'(st_seq[i]));
      expect_val($sformatf("hit_health_r_t%0d", i + 1), 8'(hr_seq[i]));
      do_tick();
      e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
      if ({6'b0, p1_state} !== e) begin
        errors++; $display("FAIL %s: got %0d, expected %0d", n, p1_state, e);
      end
      e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
      if ({3'b0, health_r} !== e) begin
        errors++; $display("FAIL %s: got %0d, expected %0d", n, health_r, e);
      end
    end
  endtask

  task automatic test_block_range_cooldown();
    logic [7:0] e;
    string n;
    int st_seq[8] = '{3, 3, 3, 3, 3, 0, 0, 0};
    in_range = 1'b1; p2_block = 1'b1;
    expect_val("blocked_health_r", 8'd27);
    play(1'b1, 1'b0);
    p2_block = 1'b0;
    e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
    if ({3'b0, health_r} !== e) begin
      errors++; $display("FAIL %s: got %0d, expected %0d", n, health_r, e);
    end
    in_range = 1'b0;
    expect_val("no_range_health_r", 8'd27);
    play(1'b1, 1'b0);
    e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
    if ({3'b0, health_r} !== e) begin
      errors++; $display("FAIL %s: got %0d, expected %0d", n, health_r, e);
    end
    press(1'b1, 1'b0);
    repeat (5) do_tick();
    expect_val("cooldown_entry_state", 8'd3);
    e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
    if ({6'b0, p1_state} !== e) begin
      errors++; $display("FAIL %s: got %0d, expected %0d", n, p1_state, e);
    end
    press(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      expect_val($sformatf("cooldown_press_state_t%0d", i + 6), 8'(st_seq[i]));
      do_tick();
      e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
      if ({6'b0, p1_state} !== e) begin
        errors++; $display("FAIL %s: got %0d, expected %0d", n, p1_state, e);
      end
    end
  endtask

  task automatic test_trade_saturation();
    logic [7:0] obs[6];
    logic [7:0] e;
    string n;
    in_range = 1'b1;
    // 8 trades: 31->7 and 27->3, then top-ups to reach 2/2
    repeat (8) play(1'b1, 1'b1);
    p2_block = 1'b1;
    play(1'b1, 1'b0);
    p2_block = 1'b0;
    play(1'b0, 1'b1);
    p1_block = 1'b1;
    play(1'b0, 1'b1);
    play(1'b0, 1'b1);
    p1_block = 1'b0;
    expect_val("preset_health_l", 8'd2);
    expect_val("preset_health_r", 8'd2);
    obs[0] = {3'b0, health_l};
    obs[1] = {3'b0, health_r};
    for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
      if (obs[i] !== e) begin
        errors++; $display("FAIL %s: got %0d, expected %0d", n, obs[i], e);
      end
    end
    press(1'b1, 1'b1);
    expect_val("trade_health_l", 8'd0);
    expect_val("trade_health_r", 8'd0);
    expect_val("trade_round", 8'd2);
    expect_val("trade_winner", 8'd3);
    expect_val("trade_p1_state", 8'd0);
    expect_val("trade_p2_state", 8'd0);
    repeat (4) do_tick();
    obs[0] = {3'b0, health_l};
    obs[1] = {3'b0, health_r};
    obs[2] = {6'b0, round_state};
    obs[3] = {6'b0, winner};
    obs[4] = {6'b0, p1_state};
    obs[5] = {6'b0, p2_state};
    for (int i = 0; i < 6; i++) begin
      e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
      if (obs[i] !== e) begin
        errors++; $display("FAIL %s: got %0d, expected %0d", n, obs[i], e);
      end
    end
    repeat (40) do_tick();
    expect_val("trade_end_round", 8'd0);
    expect_val("trade_end_winner", 8'd3);
    obs[0] = {6'b0, round_state};
    obs[1] = {6'b0, winner};
    for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
      if (obs[i] !== e) begin
        errors++; $display("FAIL %s: got %0d, expected %0d", n, obs[i], e);
      end
    end
  endtask

  task automatic test_ko_timing();
    logic [7:0] obs[4];
    logic [7:0] e;
    string n;
    start = 1'b1;
    expect_val("ko_start_round", 8'd1);
    expect_val("ko_start_winner_cleared", 8'd0);
    do_tick();
    start = 1'b0;
    obs[0] = {6'b0, round_state};
    obs[1] = {6'b0, winner};
    for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
      if (obs[i] !== e) begin
        errors++; $display("FAIL %s: got %0d, expected %0d", n, obs[i], e);
      end
    end
    in_range = 1'b1;
    repeat (10) play(1'b1, 1'b0);
    press(1'b1, 1'b0);
    expect_val("ko_health_r", 8'd0);
    expect_val("ko_health_l", 8'd31);
    expect_val("ko_round", 8'd2);
    expect_val("ko_winner", 8'd1);
    repeat (4) do_tick();
    obs[0] = {3'b0, health_r};
    obs[1] = {3'b0, health_l};
    obs[2] = {6'b0, round_state};
    obs[3] = {6'b0, winner};
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
      if (obs[i] !== e) begin
        errors++; $display("FAIL %s: got %0d, expected %0d", n, obs[i], e);
      end
    end
    for (int k = 1; k <= 40; k++) begin
      if (k == 1) begin
        press(1'b1, 1'b1);
        expect_val("ko_attack_ignored_p1", 8'd0);
        expect_val("ko_attack_ignored_p2", 8'd0);
      end
      expect_val($sformatf("ko_round_tick%0d", k), (k < 40) ? 8'd2 : 8'd0);
      do_tick();
      if (k == 1) begin
        e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if ({6'b0, p1_state} !== e) begin
          errors++; $display("FAIL %s: got %0d, expected %0d", n, p1_state, e);
        end
        e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
        if ({6'b0, p2_state} !== e) begin
          errors++; $display("FAIL %s: got %0d, expected %0d", n, p2_state, e);
        end
      end
      e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
      if ({6'b0, round_state} !== e) begin
        errors++; $display("FAIL %s: got %0d, expected %0d", n, round_state, e);
      end
    end
    expect_val("idle_health_l", 8'd31);
    expect_val("idle_health_r", 8'd31);
    expect_val("idle_winner_held", 8'd1);
    obs[0] = {3'b0, health_l};
    obs[1] = {3'b0, health_r};
    obs[2] = {6'b0, winner};
    for (int i = 0; i < 3; i++) begin
      e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
      if (obs[i] !== e) begin
        errors++; $display("FAIL %s: got %0d, expected %0d", n, obs[i], e);
      end
    end
    repeat (3) do_tick();
    expect_val("idle_winner_still_held", 8'd1);
    e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
    if ({6'b0, winner} !== e) begin
      errors++; $display("FAIL %s: got %0d, expected %0d", n, winner, e);
    end
  endtask

  task automatic test_mid_round_reset();
    logic [7:0] obs[4];
    logic [7:0] e;
    string n;
    start = 1'b1;
    do_tick();
    start = 1'b0;
    in_range = 1'b1;
    repeat (2) play(1'b1, 1'b0);
    press(1'b1, 1'b0);
    repeat (3) do_tick();
    expect_val("pre_reset_p1_state", 8'd2);
    expect_val("pre_reset_health_r", 8'd25);
    obs[0] = {6'b0, p1_state};
    obs[1] = {3'b0, health_r};
    for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
      if (obs[i] !== e) begin
        errors++; $display("FAIL %s: got %0d, expected %0d", n, obs[i], e);
      end
    end
    reset = 1'b1;
    expect_val("mid_reset_health_r", 8'd31);
    expect_val("mid_reset_round", 8'd0);
    expect_val("mid_reset_p1_state", 8'd0);
    expect_val("mid_reset_winner", 8'd0);
    @(negedge clk);
    obs[0] = {3'b0, health_r};
    obs[1] = {6'b0, round_state};
    obs[2] = {6'b0, p1_state};
    obs[3] = {6'b0, winner};
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
      if (obs[i] !== e) begin
        errors++; $display("FAIL %s: got %0d, expected %0d", n, obs[i], e);
      end
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_unblocked_hit();
    test_block_range_cooldown();
    test_trade_saturation();
    test_ko_timing();
    test_mid_round_reset();
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/combat_round_controller.md
Name: combat_round_controller

Overview:
- Sequences one fight round between player 1 (left) and player 2 (right).
- Runs one attack FSM per player, arbitrates hits including simultaneous trades, applies damage to both health registers, and detects KO.
- Outputs drive the status bar (health_l, health_r) and the sprite attack-pose state.
- All timing advances on the 20 Hz game tick; the block runs on the 100 MHz system clock.

Parameters:
- MAX_HEALTH, 31, health after reset and at round start (5-bit).
- HIT_DAMAGE, 3, damage of an unblocked hit.
- BLOCK_DAMAGE, 1, damage when the defender is blocking.
- WINDUP_TICKS, 2, ticks spent in WINDUP.
- ACTIVE_TICKS, 2, ticks spent in ACTIVE (hit window).
- COOLDOWN_TICKS, 6, ticks spent in COOLDOWN.
- KO_TICKS, 40, ticks held in KO before returning to IDLE.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- tick  in  1  one-clk-wide game tick enable (20 Hz).
- start  in  1  level; begins a round from IDLE.
- p1_attack, p2_attack  in  1  attack buttons, level, already synchronised.
- p1_block, p2_block  in  1  block buttons, level.
- in_range  in  1  players overlap or are adjacent (from collision detection).
- health_l  out  5  player 1 health.
- health_r  out  5  player 2 health.
- p1_state, p2_state  out  2  attack FSM state: 0 READY, 1 WINDUP, 2 ACTIVE, 3 COOLDOWN.
- round_state  out  2  0 IDLE, 1 FIGHT, 2 KO.
- winner  out  2  0 none, 1 player 1, 2 player 2, 3 draw.

Behaviour:
- Reset, synchronous and dominant over all other inputs:
  - round_state = IDLE, health_l = health_r = MAX_HEALTH.
  - p1_state = p2_state = READY, winner = 0.
  - All pending flags, tick counters and hit_done flags cleared.
- Clock: every register updates on posedge clk only. Apart from the pending latch, state changes happen only in cycles where tick = 1.
- Round FSM:
  - IDLE:
    - Health is held at MAX_HEALTH and attack FSMs are held in READY.
    - start = 1 in a tick cycle → FIGHT. winner is cleared on entry to FIGHT.
  - FIGHT:
    - Attack FSMs run.
    - After damage is applied in a tick, if either health = 0 → KO, with winner = 1 if only health_r = 0, 2 if only health_l = 0, 3 if both.
  - KO:
    - Attack FSMs are forced to READY and health is frozen.
    - The counter runs KO_TICKS ticks, then → IDLE. winner is held through IDLE until the next FIGHT.
- Attack request latch, per player:
  - Rising edge of pX_attack (edge-detect register on clk) sets pending while round_state = FIGHT and pX_state = READY.
  - Edges in any other state are dropped.
  - pending is cleared when consumed.
- Attack FSM, per player, evaluated in tick cycles:
  - READY: if pending → WINDUP, counter = WINDUP_TICKS - 1, pending cleared.
  - WINDUP / ACTIVE / COOLDOWN: count down. At 0 → next state, loading that state's TICKS - 1. COOLDOWN at 0 → READY.
  - Blocking does not affect the attacker's own FSM.
- Hit resolution, in tick cycles while FIGHT:
  - The attacker is in ACTIVE, in_range = 1, and hit_done = 0 for the current attack → hit; set hit_done.
  - hit_done clears on entry to WINDUP. At most one hit per attack.
  - The defender's block counts only if the defender's state = READY; otherwise full damage applies.
  - Damage = BLOCK_DAMAGE if pX_block and READY, else HIT_DAMAGE.
  - Subtraction saturates at 0, computed at 6-bit width, so there is no wrap-around.
  - Simultaneous hits from both players in the same tick are both applied; a double KO gives winner = 3.
  - The KO check uses post-damage values in the same cycle. Round_state shows KO in the cycle after the damaging tick.
- Latency:
  - Press to ACTIVE = WINDUP_TICKS ticks after the first tick following the press.
  - Health updates one clk after the hitting tick cycle.
- start asserted outside IDLE is ignored.
- reset mid-round returns everything to reset values in the next cycle.

Test Plan:
- Reset check: assert reset for 3 clk with buttons held → health_l = health_r = 31, round_state = 0, states = 0, winner = 0.
- Unblocked hit: start, then a p1_attack pulse with in_range = 1, p2 idle → p1_state goes 1, 1, 2 across ticks. health_r = 28 one clk after the first ACTIVE tick and stays 28 through ACTIVE. p1_state returns to 0 after 6 COOLDOWN ticks.
- Blocked hit and no range: repeat the hit with p2_block = 1 and p2 READY → health_r drops by 1. Repeat with in_range = 0 → no change. Press p1_attack again during COOLDOWN → ignored, p1_state stays 3 → 0 with no new WINDUP.
- Trade and saturation: preset health_l = health_r = 2 via a hit sequence, then both players attack on the same tick → both healths = 0 (saturated, not 31), round_state = 2, winner = 3.
- KO timing: a single KO by p1 → winner = 1. Attacks during KO are ignored. round_state returns to 0 exactly 40 ticks after KO, with health back at 31 and winner still 1 until the next start.
- Mid-round reset: assert reset during p1 ACTIVE with health_r = 25 → next clk health_r = 31, round_state = 0, p1_state = 0.
